// File: rtl/mult_arbiter_if.sv
// rtl/mult_arbiter_if.sv - request, multiplier and response signals of mult_arbiter
//
// Groups every handshake signal of the two-requester multiplier arbiter.
//   master : the environment (requesters and the shared multiplier)
//   slave  : the arbiter itself
// Requester i operands live at req_x/req_y[i*WIDTH +: WIDTH].
interface mult_arbiter_if #(
  parameter int WIDTH = 4
);
  logic [1:0]         req_valid;
  logic [2*WIDTH-1:0] req_x;
  logic [2*WIDTH-1:0] req_y;
  logic [1:0]         req_ready;
  logic               m_start;
  logic [WIDTH-1:0]   m_x;
  logic [WIDTH-1:0]   m_y;
  logic               m_ready;
  logic [2*WIDTH-1:0] m_product;
  logic [1:0]         rsp_valid;
  logic [2*WIDTH-1:0] rsp_product;
  logic               rsp_err;
  logic               busy;

  modport master (
    output req_valid, req_x, req_y, m_ready, m_product,
    input  req_ready, m_start, m_x, m_y, rsp_valid, rsp_product, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_x, req_y, m_ready, m_product,
    output req_ready, m_start, m_x, m_y, rsp_valid, rsp_product, rsp_err, busy
  );
endinterface

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin arbiter sharing one multiplier between two requesters
//
// Ports:
//   clk_in  : single clock, all state on the rising edge
//   rst_in  : asynchronous active-high reset
//   bus     : mult_arbiter_if.slave
//     req_valid/req_x/req_y -> request and packed operands, held until granted
//     req_ready             <- one-cycle accept pulse to the granted requester
//     m_start/m_x/m_y       <- one-cycle start pulse and registered operands
//     m_ready/m_product     -> multiplier completion pulse and result
//     rsp_valid/rsp_product <- one-cycle response pulse and held result
//     rsp_err               <- timeout flag, meaningful with rsp_valid
//     busy                  <- high whenever the FSM is not in IDLE
// Optional feature: define MULT_ARBITER_TIMEOUT_EN to bound WAIT to TIMEOUT
// cycles; without it WAIT lasts until m_ready and rsp_err is tied low.
module mult_arbiter #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 32
) (
  input logic           clk_in,
  input logic           rst_in,
  mult_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t state;
  logic   grant;       // owner of the in-flight operation
  logic   last_grant;  // reset to 1 so requester 0 wins the first tie
  logic   pick;        // requester that would be granted this cycle

  // Ties go to the requester that was not served last; a lone request wins.
  always_comb begin
    pick = 1'b0;
    if (&bus.req_valid) pick = ~last_grant;
    else                pick = bus.req_valid[1];
  end

`ifdef MULT_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;  // WAIT cycles already spent, minus one
`else
  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state           <= IDLE;
      grant           <= 1'b0;
      last_grant      <= 1'b1;
      bus.req_ready   <= '0;
      bus.m_start     <= 1'b0;
      bus.m_x         <= '0;
      bus.m_y         <= '0;
      bus.rsp_valid   <= '0;
      bus.rsp_product <= '0;
      bus.busy        <= 1'b0;
`ifdef MULT_ARBITER_TIMEOUT_EN
      wait_cnt        <= '0;
      bus.rsp_err     <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low so each is high for exactly one cycle.
      bus.req_ready <= '0;
      bus.m_start   <= 1'b0;
      bus.rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            state         <= ISSUE;
            grant         <= pick;
            last_grant    <= pick;
            bus.m_x       <= pick ? bus.req_x[WIDTH +: WIDTH] : bus.req_x[0 +: WIDTH];
            bus.m_y       <= pick ? bus.req_y[WIDTH +: WIDTH] : bus.req_y[0 +: WIDTH];
            bus.req_ready <= {pick, ~pick};
            bus.m_start   <= 1'b1;
            bus.busy      <= 1'b1;
          end
        end
        ISSUE: begin
          // m_ready is deliberately not looked at here.
          state <= WAIT;
`ifdef MULT_ARBITER_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (bus.m_ready) begin
            state           <= RESP;
            bus.rsp_product <= bus.m_product;
            bus.rsp_valid   <= {grant, ~grant};
`ifdef MULT_ARBITER_TIMEOUT_EN
            bus.rsp_err     <= 1'b0;
`endif
          end
`ifdef MULT_ARBITER_TIMEOUT_EN
          // A completion in the final WAIT cycle wins over the timeout.
          else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            state           <= RESP;
            bus.rsp_product <= '0;
            bus.rsp_valid   <= {grant, ~grant};
            bus.rsp_err     <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        RESP: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - self-checking bench for mult_arbiter
module tb_mult_arbiter;
  localparam int W     = 4;
  localparam int W2    = 2 * W;
  localparam int TO    = 32;
  localparam int NEVER = 32'h7fffffff;

  logic clk_in = 1'b0;
  logic rst_in;
  always #5 clk_in = ~clk_in;

  mult_arbiter_if #(.WIDTH(W)) bus ();
  mult_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (.clk_in(clk_in), .rst_in(rst_in), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i >= 0 && i < q.size()) ? q[i] : -1;
  endfunction

  // Observed transaction logs (filled by the monitor).
  int g_own[$];
  int g_cyc[$];
  int r_cyc[$];
  int r_prod[$];
  int r_err[$];

  // Multiplier stand-in: answers mul_lat cycles after m_start (0 = never).
  int mul_lat = 4;
  int mul_due = -1;
  logic [W2-1:0] mul_res = '0;

  initial begin
    bus.m_ready   = 1'b0;
    bus.m_product = '0;
    forever begin
      @(posedge clk_in);
      #1;
      if (cyc + 1 == mul_due) begin
        bus.m_ready   = 1'b1;
        bus.m_product = mul_res;
      end else begin
        bus.m_ready   = 1'b0;
        bus.m_product = '1;
      end
    end
  end

  // Transaction model: an operation is issued the cycle after an idle
  // arbiter sees a request, answered the cycle after the multiplier's
  // result (or the timeout), and the arbiter is free the cycle after that.
  bit            job_on = 1'b0;
  bit            job_own;
  int            job_issue;
  int            job_done;
  logic [W-1:0]  job_x, job_y;
  bit            last_g = 1'b1;
  int            free_from = 0;
  logic [W-1:0]  e_mx = '0, e_my = '0;
  logic [W2-1:0] e_prod = '0;
  logic          e_err = 1'b0;

  always @(negedge clk_in) begin : mon
    logic [1:0] e_rr, e_rv;
    logic       e_ms, e_busy;
    cyc++;
    if (rst_in) begin
      job_on = 1'b0; last_g = 1'b1; free_from = cyc + 1;
      e_mx = '0; e_my = '0; e_prod = '0; e_err = 1'b0;
      e_rr = '0; e_rv = '0; e_ms = 1'b0; e_busy = 1'b0;
    end else begin
      e_rr   = (job_on && job_issue == cyc) ? (job_own ? 2'b10 : 2'b01) : 2'b00;
      e_ms   = job_on && job_issue == cyc;
      e_rv   = (job_on && job_done == cyc) ? (job_own ? 2'b10 : 2'b01) : 2'b00;
      e_busy = job_on && cyc >= job_issue;
    end
    chk("req_ready", bus.req_ready, e_rr);
    chk("m_start", bus.m_start, e_ms);
    chk("m_x", bus.m_x, e_mx);
    chk("m_y", bus.m_y, e_my);
    chk("rsp_valid", bus.rsp_valid, e_rv);
    chk("rsp_product", bus.rsp_product, e_prod);
    chk("rsp_err", bus.rsp_err, e_err);
    chk("busy", bus.busy, e_busy);

    if (bus.req_ready != 2'b00) begin
      g_own.push_back(bus.req_ready[1] ? 1 : 0);
      g_cyc.push_back(cyc);
    end
    if (bus.rsp_valid != 2'b00) begin
      r_cyc.push_back(cyc);
      r_prod.push_back(int'(bus.rsp_product));
      r_err.push_back(bus.rsp_err ? 1 : 0);
    end
    if (bus.m_start && mul_lat > 0) begin
      mul_due = cyc + mul_lat;
      mul_res = W2'(bus.m_x) * W2'(bus.m_y);
    end

    if (!rst_in) begin
      if (job_on && job_done == NEVER && cyc > job_issue) begin
        if (bus.m_ready) begin
          job_done = cyc + 1;
          e_prod   = W2'(job_x) * W2'(job_y);
          e_err    = 1'b0;
        end
`ifdef MULT_ARBITER_TIMEOUT_EN
        else if (cyc - job_issue == TO) begin
          job_done = cyc + 1;
          e_prod   = '0;
          e_err    = 1'b1;
        end
`endif
      end else if (job_on && job_done == cyc) begin
        job_on    = 1'b0;
        free_from = cyc + 1;
      end else if (!job_on && cyc >= free_from && bus.req_valid != 2'b00) begin
        if (bus.req_valid == 2'b11) job_own = ~last_g;
        else                        job_own = bus.req_valid[1];
        last_g    = job_own;
        job_x     = job_own ? bus.req_x[W +: W] : bus.req_x[0 +: W];
        job_y     = job_own ? bus.req_y[W +: W] : bus.req_y[0 +: W];
        e_mx      = job_x;
        e_my      = job_y;
        job_issue = cyc + 1;
        job_done  = NEVER;
        job_on    = 1'b1;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    cycles(1);
    rst_in = 1'b0;
  endtask

  task automatic set_req(input logic [1:0] v, input int x0, input int y0, input int x1, input int y1);
    bus.req_x     = {W'(x1), W'(x0)};
    bus.req_y     = {W'(y1), W'(y0)};
    bus.req_valid = v;
  endtask

  task automatic wait_grant(input int budget, output int own);
    own = -1;
    for (int k = 0; k < budget && own < 0; k++) begin
      @(negedge clk_in);
      if (bus.req_ready != 2'b00) own = bus.req_ready[1] ? 1 : 0;
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_rsp(input int budget, output logic [W2-1:0] p, output logic e, output logic [1:0] who);
    who = 2'b00; p = '0; e = 1'b0;
    for (int k = 0; k < budget && who == 2'b00; k++) begin
      @(negedge clk_in);
      if (bus.rsp_valid != 2'b00) begin
        who = bus.rsp_valid; p = bus.rsp_product; e = bus.rsp_err;
      end
    end
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, r0, own;
    logic [W2-1:0] p;
    logic e;
    logic [1:0] who;

    rst_in = 1'b1;
    set_req(2'b00, 0, 0, 0, 0);
    repeat (3) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    cycles(2);
    chk("reset_busy", bus.busy, 0);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_rsp_product", bus.rsp_product, 0);

    // Single request, multiplier answers 4 cycles after m_start.
    mul_lat = 4;
    g0 = g_cyc.size(); r0 = r_cyc.size();
    set_req(2'b01, 3, 5, 0, 0);
    wait_grant(40, own);
    chk("single_owner", own, 0);
    bus.req_valid = 2'b00;
    wait_rsp(40, p, e, who);
    chk("single_who", who, 2'b01);
    chk("single_product", p, 15);
    chk("single_err", e, 0);
    chk("single_latency", qget(r_cyc, r0) - qget(g_cyc, g0), 5);
    cycles(3);

    // Contention from a fresh reset: strict alternation starting at 0.
    do_reset();
    mul_lat = 1;
    g0 = g_cyc.size(); r0 = r_cyc.size();
    set_req(2'b11, 2, 3, 4, 5);
    cycles(18);
    bus.req_valid = 2'b00;
    cycles(8);
    chk("cont_ngrant", g_cyc.size() - g0, 5);
    for (int k = 0; k < 4; k++) begin
      chk("cont_owner", qget(g_own, g0 + k), k % 2);
      chk("cont_product", qget(r_prod, r0 + k), (k % 2 == 0) ? 6 : 20);
    end
    for (int k = 1; k < 4; k++)
      chk("cont_spacing", qget(g_cyc, g0 + k) - qget(g_cyc, g0 + k - 1), 4);

    // Requester 1 alone, continuous, 1-cycle multiplier.
    g0 = g_cyc.size(); r0 = r_cyc.size();
    set_req(2'b10, 0, 0, 7, 9);
    cycles(13);
    bus.req_valid = 2'b00;
    cycles(6);
    chk("b2b_ngrant", g_cyc.size() - g0, 4);
    for (int k = 0; k < 4; k++) chk("b2b_owner", qget(g_own, g0 + k), 1);
    for (int k = 1; k < 4; k++)
      chk("b2b_spacing", qget(g_cyc, g0 + k) - qget(g_cyc, g0 + k - 1), 4);
    chk("b2b_product", qget(r_prod, r0), 63);

    // Requester 0 withdraws while requester 1 is being served.
    mul_lat = 6;
    g0 = g_cyc.size(); r0 = r_cyc.size();
    set_req(2'b10, 0, 0, 2, 7);
    wait_grant(40, own);
    chk("drop_owner", own, 1);
    set_req(2'b01, 9, 9, 2, 7);
    cycles(2);
    bus.req_valid = 2'b00;
    cycles(12);
    chk("drop_ngrant", g_cyc.size() - g0, 1);
    chk("drop_nrsp", r_cyc.size() - r0, 1);
    chk("drop_product", qget(r_prod, r0), 14);

    // Reset while waiting for the multiplier; its late result is ignored.
    mul_lat = 5;
    r0 = r_cyc.size();
    set_req(2'b10, 0, 0, 3, 3);
    wait_grant(40, own);
    chk("rstw_owner", own, 1);
    bus.req_valid = 2'b00;
    cycles(1);
    do_reset();
    cycles(8);
    chk("rstw_nrsp", r_cyc.size() - r0, 0);
    chk("rstw_busy", bus.busy, 0);

    // Tie after reset goes to requester 0; full-width product 15*15.
    mul_lat = 2;
    g0 = g_cyc.size();
    set_req(2'b11, 15, 15, 1, 2);
    wait_grant(40, own);
    chk("bound_owner", own, 0);
    bus.req_valid = 2'b00;
    wait_rsp(40, p, e, who);
    chk("bound_who", who, 2'b01);
    chk("bound_product", p, 225);
    cycles(6);
    chk("bound_ngrant", g_cyc.size() - g0, 1);

`ifdef MULT_ARBITER_TIMEOUT_EN
    // Multiplier never answers: timeout after 32 WAIT cycles.
    mul_lat = 0;
    g0 = g_cyc.size(); r0 = r_cyc.size();
    set_req(2'b01, 5, 6, 0, 0);
    wait_grant(40, own);
    bus.req_valid = 2'b00;
    wait_rsp(60, p, e, who);
    chk("to_who", who, 2'b01);
    chk("to_err", e, 1);
    chk("to_product", p, 0);
    chk("to_latency", qget(r_cyc, r0) - qget(g_cyc, g0), 33);
    cycles(3);
    // Answer in the last WAIT cycle counts as a normal completion.
    mul_lat = 32;
    g0 = g_cyc.size(); r0 = r_cyc.size();
    set_req(2'b01, 5, 6, 0, 0);
    wait_grant(40, own);
    bus.req_valid = 2'b00;
    wait_rsp(60, p, e, who);
    chk("edge_err", e, 0);
    chk("edge_product", p, 30);
    chk("edge_latency", qget(r_cyc, r0) - qget(g_cyc, g0), 33);
`else
    // Without the timeout a slow multiplier is simply waited for.
    mul_lat = 40;
    g0 = g_cyc.size(); r0 = r_cyc.size();
    set_req(2'b01, 5, 6, 0, 0);
    wait_grant(40, own);
    bus.req_valid = 2'b00;
    wait_rsp(60, p, e, who);
    chk("slow_who", who, 2'b01);
    chk("slow_err", e, 0);
    chk("slow_product", p, 30);
    chk("slow_latency", qget(r_cyc, r0) - qget(g_cyc, g0), 41);
`endif
    cycles(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 32, max cycles to wait for multiplier completion.
REQ-003 SHALL have port clk_in  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  2  per-requester request; held with operands until granted.
REQ-006 SHALL have port req_x  input  2*WIDTH  operand x; requester i at bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port req_y  input  2*WIDTH  operand y; same packing as req_x.
REQ-008 SHALL have port req_ready  output  2  one-cycle accept pulse to the granted requester.
REQ-009 SHALL have port m_start  output  1  one-cycle start pulse to the shared multiplier.
REQ-010 SHALL have port m_x, m_y  output  WIDTH each  registered operands to the multiplier.
REQ-011 SHALL have port m_ready  input  1  multiplier completion pulse.
REQ-012 SHALL have port m_product  input  2*WIDTH  multiplier result, valid when m_ready=1.
REQ-013 SHALL have port rsp_valid  output  2  one-cycle response pulse to the owning requester.
REQ-014 SHALL have port rsp_product  output  2*WIDTH  result, valid with rsp_valid.
REQ-015 SHALL have port rsp_err  output  1  timeout flag, valid with rsp_valid.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-018 IDLE: if any req_valid, SHALL latch grant g and operands of g, go to ISSUE; else stay.
REQ-019 Arbitration SHALL be round-robin: both valid -> grant requester != last_grant; one valid -> that one.
REQ-020 last_grant SHALL update only on entry to ISSUE.
REQ-021 ISSUE (exactly one cycle): req_ready[g]=1, m_start=1, m_x/m_y = latched operands; next WAIT.
REQ-022 m_ready SHALL be ignored in ISSUE; only sampled in WAIT.
REQ-023 WAIT: on m_ready=1 SHALL capture m_product, clear error, go to RESP.
REQ-024 RESP (one cycle): rsp_valid[g]=1, rsp_product=captured value, rsp_err as latched; next IDLE.
REQ-025 req_valid dropped before grant SHALL produce no grant and no response.
REQ-026 req_valid held through RESP SHALL be treated as a new request in the following IDLE.
REQ-027 Minimum turnaround SHALL be 4 cycles from grant latch to next grant latch for a 1-cycle multiplier.
REQ-028 Outputs req_ready, m_start, rsp_valid SHALL never be high for more than one consecutive cycle.
REQ-029 rsp_product SHALL hold its value outside RESP; no output SHALL depend combinationally on inputs.

Reset
REQ-030 rst_in=1 SHALL immediately force IDLE, last_grant=1 (requester 0 wins first tie), all outputs 0.
REQ-031 Reset mid-operation SHALL drop the in-flight request with no response; multiplier result later ignored.

Configuration
REQ-032 Macro MULT_ARBITER_TIMEOUT_EN SHALL enable a WAIT-cycle counter of width $clog2(TIMEOUT+1).
REQ-033 With macro: after TIMEOUT cycles in WAIT without m_ready, SHALL go to RESP with rsp_product=0, rsp_err=1.
REQ-034 With macro: m_ready and timeout in same cycle SHALL resolve as normal completion (rsp_err=0).
REQ-035 Without macro: no counter; WAIT lasts indefinitely; rsp_err SHALL be tied 0.

Verification
REQ-036 Single: req_valid=01, x0=3, y0=5, m_ready 4 cycles after m_start with 15 -> rsp_valid=01, rsp_product=15, rsp_err=0.
REQ-037 Contention: req_valid=11 held, x0=2,y0=3,x1=4,y1=5 -> grants 0,1,0,1 in order; products 6,20 alternating.
REQ-038 Back-to-back: requester 1 alone, continuous, 1-cycle multiplier -> grants every 4 cycles, req_ready pulses 1 cycle.
REQ-039 Reset mid-WAIT: rst_in pulse during WAIT, then m_ready -> no rsp_valid; busy=0; next req gets requester-0 priority.
REQ-040 Timeout (macro on, TIMEOUT=32): m_ready never asserted -> rsp_valid after 32 WAIT cycles, rsp_err=1, rsp_product=0.
REQ-041 Boundary: x0=15, y0=15 with WIDTH=4 -> rsp_product=225 carried unmodified at full 8-bit width.
